hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline hazard controller for the five-stage RISC-V core. It covers the hazards that EX-stage forwarding cannot resolve: load-use dependences, taken-branch flushes and data-memory wait states. It sits beside the ID stage and drives the write-enable, flush and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also runs a bounded wait-state FSM with timeout detection.

## Interface
Parameters:
- MAX_WAIT, 16, maximum consecutive data-memory wait cycles before timeout (≥2)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IF_IDrs1, IF_IDrs2  in  5  source registers of instruction in ID
- IF_IDuseRs1, IF_IDuseRs2  in  1  ID instruction actually reads rs1/rs2
- ID_EXmemRead  in  1  instruction in EX is a load
- ID_EXrd  in  5  destination of instruction in EX
- branchTaken  in  1  EX resolved a taken branch/jump
- EX_MEMmemAccess  in  1  instruction in MEM accesses data memory
- dmemReady  in  1  data memory completes access this cycle
- PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite  out  1  stage register enables
- IF_IDflush, ID_EXflush  out  1  load NOP into stage register
- MEM_WBbubble  out  1  load NOP into MEM/WB
- memTimeout  out  1  sticky wait-timeout error
- stallCycles, flushCount  out  CNT_W  performance counters

## Operation
- Definitions:
  - loadUse = ID_EXmemRead && ID_EXrd!=0 && ((IF_IDuseRs1 && IF_IDrs1==ID_EXrd) || (IF_IDuseRs2 && IF_IDrs2==ID_EXrd))
  - memWait = EX_MEMmemAccess && !dmemReady
- Default outputs: all *write=1, flushes=0, MEM_WBbubble=0.
- FSM states: RUN, MEM_WAIT, ERROR.
- RUN, evaluated in priority order:
  - memWait: freeze. All four *write=0, MEM_WBbubble=1, next state MEM_WAIT, waitCnt←1.
  - Else branchTaken: IF_IDflush=1, ID_EXflush=1, PCwrite=1; stay in RUN.
  - Else loadUse: PCwrite=0, IF_IDwrite=0, ID_EXflush=1 (exactly one bubble); stay in RUN. The bubble clears ID_EXmemRead, so the hazard never re-detects.
- MEM_WAIT:
  - dmemReady=1: no freeze this cycle. Branch and load-use are evaluated as in RUN, so a branch held in EX acts now. Next state RUN.
  - dmemReady=0: freeze as above and waitCnt++. If waitCnt==MAX_WAIT-1, next state ERROR.
- ERROR: freeze held permanently and memTimeout=1. Leaves only via reset.
- branchTaken and loadUse are ignored while frozen; the frozen stages keep their values, so both hazards re-present themselves on release.
- rd==0 never causes a stall.

## Timing
- All hazard outputs are combinational from state plus inputs, valid in the same cycle. The unit adds zero latency to stage registers.
- State, waitCnt, memTimeout and the counters update on the clk rising edge.
- Load-use costs exactly 1 stall cycle. A taken branch costs 2 flushed slots.
- A memory access with N wait cycles freezes the pipe exactly N cycles, provided N < MAX_WAIT.
- Reset (asynchronous, any state, including mid-wait):
  - state=RUN, waitCnt=0, memTimeout=0, stallCycles=0, flushCount=0
  - outputs revert to RUN-combinational values
- Simultaneous memWait and branchTaken: freeze wins; the flush occurs on the release cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stallCycles increments on every cycle with PCwrite=0.
  - flushCount increments on every cycle with IF_IDflush=1.
  - Both saturate at 2^CNT_W−1 and do not wrap.
- Not defined: both ports are driven constant 0 and no counter flops are instantiated.

## Structure
- hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERROR)
  - REG_ADDR_W=5
  - the zero-register constant
- One sub-module, sat_counter (parameter width; inputs clk, rst_n, inc; output count), instantiated twice under HAZARD_PERF_CNT_EN.

## Test plan
- Load-use: ID_EXmemRead=1, ID_EXrd=5, IF_IDrs2=5, IF_IDuseRs2=1 → one cycle with PCwrite=0, IF_IDwrite=0, ID_EXflush=1; the next cycle has default outputs.
- rd=x0: ID_EXmemRead=1, ID_EXrd=0, IF_IDrs1=0 → no stall. Also useRs1=0 with matching rs1 → no stall.
- Wait states: EX_MEMmemAccess=1, dmemReady low for 3 cycles → freeze asserted 3 cycles, released on the 4th. With HAZARD_PERF_CNT_EN, stallCycles=3.
- Branch during wait: branchTaken=1 while memWait for 2 cycles → no flush while frozen; IF_IDflush=ID_EXflush=1 on the release cycle; flushCount=1.
- Timeout: MAX_WAIT=4, dmemReady held 0 → memTimeout=1 after the 4th frozen cycle. The freeze persists, and asserting rst_n=0 asynchronously clears everything.
- Counter saturation: CNT_W=4, 20 consecutive load-use stalls → stallCycles sticks at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard stall unit
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// sat_counter: saturating up-counter (clk, rst_n async active-low, inc -> count)
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use/branch/mem-wait stall control with wait timeout; HAZARD_PERF_CNT_EN enables stallCycles/flushCount counters
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] IF_IDrs1,
  input  logic [REG_ADDR_W-1:0] IF_IDrs2,
  input  logic                  IF_IDuseRs1,
  input  logic                  IF_IDuseRs2,
  input  logic                  ID_EXmemRead,
  input  logic [REG_ADDR_W-1:0] ID_EXrd,
  input  logic                  branchTaken,
  input  logic                  EX_MEMmemAccess,
  input  logic                  dmemReady,
  output logic                  PCwrite,
  output logic                  IF_IDwrite,
  output logic                  ID_EXwrite,
  output logic                  EX_MEMwrite,
  output logic                  IF_IDflush,
  output logic                  ID_EXflush,
  output logic                  MEM_WBbubble,
  output logic                  memTimeout,
  output logic [CNT_W-1:0]      stallCycles,
  output logic [CNT_W-1:0]      flushCount
);
  localparam int WW = $clog2(MAX_WAIT);
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic load_use, freeze;
  assign load_use = ID_EXmemRead && ID_EXrd != ZERO_REG &&
                    ((IF_IDuseRs1 && IF_IDrs1 == ID_EXrd) || (IF_IDuseRs2 && IF_IDrs2 == ID_EXrd));
  // Once waiting, the access is held in MEM, so only dmemReady decides release.
  assign freeze = state == ERROR || (state == MEM_WAIT ? !dmemReady : EX_MEMmemAccess && !dmemReady);
  assign memTimeout = state == ERROR;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  always_comb begin
    PCwrite      = 1'b1;
    IF_IDwrite   = 1'b1;
    ID_EXwrite   = 1'b1;
    EX_MEMwrite  = 1'b1;
    IF_IDflush   = 1'b0;
    ID_EXflush   = 1'b0;
    MEM_WBbubble = 1'b0;
    state_nx     = state;
    wait_nx      = wait_cnt;
    if (freeze) begin
      PCwrite      = 1'b0;
      IF_IDwrite   = 1'b0;
      ID_EXwrite   = 1'b0;
      EX_MEMwrite  = 1'b0;
      MEM_WBbubble = 1'b1;
      if (state == RUN) begin
        state_nx = MEM_WAIT;
        wait_nx  = WW'(1);
      end else if (state == MEM_WAIT) begin
        wait_nx  = wait_cnt + 1'b1;
        state_nx = wait_cnt == WW'(MAX_WAIT - 1) ? ERROR : MEM_WAIT;
      end
    end else begin
      state_nx = RUN;
      wait_nx  = '0;
      if (branchTaken) begin
        IF_IDflush = 1'b1;
        ID_EXflush = 1'b1;
      end else if (load_use) begin
        PCwrite    = 1'b0;
        IF_IDwrite = 1'b0;
        ID_EXflush = 1'b1;
      end
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(!PCwrite), .count(stallCycles));
  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(IF_IDflush), .count(flushCount));
`else
  assign stallCycles = '0;
  assign flushCount  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench for hazard_stall_unit against a behavioural model
module tb_hazard_stall_unit;
  localparam int MW = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic use1 = 1'b0, use2 = 1'b0, mrd = 1'b0, br = 1'b0, acc = 1'b0, rdy = 1'b1;
  logic pcw, ifidw, idexw, exmemw, ifidf, idexf, bub, tmo;
  logic [CW-1:0] stall_c, flush_c;
  logic [8+2*CW-1:0] exp_q[$];
  int vectors = 0, miscompares = 0;
  int wait_run = 0, stall_m = 0, flush_m = 0;
  bit dead = 0;
  always #5 clk = ~clk;
  hazard_stall_unit #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .IF_IDrs1(rs1), .IF_IDrs2(rs2), .IF_IDuseRs1(use1), .IF_IDuseRs2(use2),
    .ID_EXmemRead(mrd), .ID_EXrd(rd), .branchTaken(br), .EX_MEMmemAccess(acc), .dmemReady(rdy),
    .PCwrite(pcw), .IF_IDwrite(ifidw), .ID_EXwrite(idexw), .EX_MEMwrite(exmemw),
    .IF_IDflush(ifidf), .ID_EXflush(idexf), .MEM_WBbubble(bub), .memTimeout(tmo),
    .stallCycles(stall_c), .flushCount(flush_c));
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      logic [8+2*CW-1:0] e, got;
      e = exp_q.pop_front();
      got = {pcw, ifidw, idexw, exmemw, ifidf, idexf, bub, tmo, stall_c, flush_c};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL vec%0d outputs got=%b required=%b (pc,ifid,idex,exmem,ifidf,idexf,bub,tmo,stall,flush)", vectors, got, e);
      end
    end
  task automatic apply(input logic rn, input logic [4:0] r1, r2, input logic u1, u2, m,
                       input logic [4:0] d, input logic b, a, y);
    bit lu, frz, stall, flush;
    @(posedge clk);
    #1;
    {rst_n, rs1, rs2, use1, use2, mrd, rd, br, acc, rdy} = {rn, r1, r2, u1, u2, m, d, b, a, y};
    if (!rn) begin
      wait_run = 0; dead = 0; stall_m = 0; flush_m = 0;
    end
    lu = m && d != 0 && ((u1 && r1 == d) || (u2 && r2 == d));
    frz = dead || (wait_run > 0 ? !y : a && !y);
    stall = frz || (!b && lu);
    flush = !frz && b;
    exp_q.push_back({!stall, !stall, !frz, !frz, flush, flush || (!frz && lu), frz, dead,
                     CW'(PERF ? stall_m : 0), CW'(PERF ? flush_m : 0)});
    if (rn) begin
      if (frz && !dead) begin
        wait_run++;
        if (wait_run == MW) dead = 1;
      end else if (!frz) wait_run = 0;
      if (stall && stall_m < SAT) stall_m++;
      if (flush && flush_m < SAT) flush_m++;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    apply(1, 1, 5, 0, 1, 1, 5, 0, 0, 1);
    idle(1);
    apply(1, 0, 3, 1, 0, 1, 0, 0, 0, 1);
    apply(1, 7, 3, 0, 0, 1, 7, 0, 0, 1);
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    for (int i = 0; i < 2; i++) apply(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);
    for (int i = 0; i < 6; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 20; i++) apply(1, 9, 2, 1, 0, 1, 9, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 3));
      apply($urandom_range(0, 39) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), d, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 6);
    end
    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
